// File: rtl/sw_handshake_host.sv
// sw_handshake_host
// Drives a processor's switch bus through one complete transaction:
// hold the processor in reset, raise the handshake line, drop it, let the
// outputs settle, then capture the LED bus and offer it as a result.
// Requests and results use a valid/ready handshake.
module sw_handshake_host #(
    parameter int RST_CYCLES    = 5,
    parameter int HOLD_CYCLES   = 2000,
    parameter int SETTLE_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_valid,
    input  logic [7:0] start_index,
    output logic       start_ready,
    output logic       result_valid,
    output logic [7:0] result_data,
    input  logic       result_ready,
    output logic       busy,
    output logic [9:0] SW,
    input  logic [7:0] LED
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_RST,
        HOLD,
        SETTLE,
        RESULT
    } state_t;

    // Each phase loads N-1 on entry and leaves on the edge where the count is
    // zero, so every phase lasts exactly N cycles.
    localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [15:0] count;
    logic [7:0]  index_q;

    // Single registered FSM: state, shared phase counter and every output.
    // Reset parks the block in IDLE with all outputs low; the first edge
    // out of reset then drives the IDLE values and opens start_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 16'd0;
            index_q      <= 8'd0;
            SW           <= 10'b0000000000;
            start_ready  <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= 8'd0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid && start_ready) begin
                        index_q     <= start_index;
                        SW          <= {2'b00, start_index};
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        count       <= RST_LOAD;
                        state       <= CPU_RST;
                    end else begin
                        SW          <= {2'b10, index_q};
                        start_ready <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                CPU_RST: begin
                    if (count == 16'd0) begin
                        SW    <= {2'b11, index_q};
                        count <= HOLD_LOAD;
                        state <= HOLD;
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                HOLD: begin
                    if (count == 16'd0) begin
                        SW    <= {2'b10, index_q};
                        count <= SETTLE_LOAD;
                        state <= SETTLE;
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                SETTLE: begin
                    if (count == 16'd0) begin
                        result_data  <= LED;
                        result_valid <= 1'b1;
                        state        <= RESULT;
                    end else begin
                        count <= count - 16'd1;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
